// File: rtl/sha2_pad.sv
// sha2_pad: SHA-256 message padder. Turns a byte-granular 512-bit AXI4-Stream
// message into whole 512-bit blocks carrying 0x80, zero fill and the 64-bit bit length.
module sha2_pad #(
    parameter int ID_BITS  = 8,
    parameter int CNT_BITS = 61
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [511:0]       s_tdata,
    input  logic [63:0]        s_tkeep,
    input  logic [ID_BITS-1:0] s_tid,
    input  logic               s_tlast,
    input  logic               s_tvalid,
    output logic               s_tready,
    output logic [511:0]       m_tdata,
    output logic [63:0]        m_tkeep,
    output logic [ID_BITS-1:0] m_tid,
    output logic               m_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               msg_done,
    output logic [63:0]        msg_len_bits,
    output logic               dbg_state
);

    // Handshake: a transfer happens on a rising edge with valid && ready; valid never
    // waits for ready, and a presented payload holds until it is taken.
    typedef enum logic {
        PASS  = 1'b0,
        EXTRA = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_BITS-1:0]   count;
    logic [511:0]          pend_data;
    logic [ID_BITS-1:0]    pend_tid;
    logic [63:0]           slot_len;
    logic                  slot_free;
    logic                  accept;
    logic                  load_pend;
    logic [6:0]            keep_cnt;
    logic [CNT_BITS-1:0]   total;
    logic [CNT_BITS+2:0]   total_bits;
    logic [63:0]           len_bits;
    logic [511:0]          last_data;
    logic [511:0]          pend_build;

    assign slot_free  = !m_tvalid || m_tready;
    assign m_tkeep    = '1;
    assign dbg_state  = (state == EXTRA);
    assign total      = count + CNT_BITS'(keep_cnt);
    assign total_bits = {total, 3'b000};
    assign len_bits   = 64'(total_bits);

    always_comb begin
        keep_cnt = '0;
        for (int k = 0; k < 64; k++) begin
            keep_cnt = keep_cnt + {6'd0, s_tkeep[k]};
        end
    end

    // Final-beat block and the block that follows it; lanes at or above the
    // byte count never carry s_tdata.
    always_comb begin
        last_data  = '0;
        pend_build = '0;
        for (int k = 0; k < 64; k++) begin
            if (7'(k) < keep_cnt) begin
                last_data[8*k +: 8] = s_tdata[8*k +: 8];
            end else if (7'(k) == keep_cnt) begin
                last_data[8*k +: 8] = 8'h80;
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (keep_cnt <= 7'd55) begin
                last_data[8*(56+j) +: 8] = len_bits[8*(7-j) +: 8];
            end
            pend_build[8*(56+j) +: 8] = len_bits[8*(7-j) +: 8];
        end
        if (keep_cnt == 7'd64) begin
            pend_build[7:0] = 8'h80;
        end
    end

    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        accept     = 1'b0;
        load_pend  = 1'b0;
        case (state)
            PASS: begin
                s_tready = slot_free;
                accept   = s_tvalid && slot_free;
                if (accept && s_tlast && keep_cnt >= 7'd56) begin
                    state_next = EXTRA;
                end
            end
            EXTRA: begin
                if (slot_free) begin
                    load_pend  = 1'b1;
                    state_next = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count        <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tdata      <= '0;
            m_tid        <= '0;
            pend_data    <= '0;
            pend_tid     <= '0;
            slot_len     <= '0;
            msg_done     <= 1'b0;
            msg_len_bits <= '0;
        end else begin
            msg_done <= m_tvalid && m_tready && m_tlast;
            if (m_tvalid && m_tready && m_tlast) begin
                msg_len_bits <= slot_len;
            end
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tid    <= s_tid;
                if (s_tlast) begin
                    m_tdata   <= last_data;
                    m_tlast   <= (keep_cnt <= 7'd55);
                    slot_len  <= len_bits;
                    count     <= '0;
                    pend_data <= pend_build;
                    pend_tid  <= s_tid;
                end else begin
                    m_tdata <= s_tdata;
                    m_tlast <= 1'b0;
                    count   <= count + CNT_BITS'(64);
                end
            end else if (load_pend) begin
                // slot_len already holds this message's length from the last beat
                m_tvalid <= 1'b1;
                m_tdata  <= pend_data;
                m_tid    <= pend_tid;
                m_tlast  <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_pad.sv
// Bench for sha2_pad: standard SHA-256 padding model over byte queues, hand vectors
// for the boundary lengths, reset-in-EXTRA sequence and randomized backpressure.
module tb_sha2_pad;

    logic         aclk = 1'b0;
    logic         areset = 1'b0;
    logic [511:0] s_tdata = '0;
    logic [63:0]  s_tkeep = '0;
    logic [7:0]   s_tid = '0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic [7:0]   m_tid;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         msg_done;
    logic [63:0]  msg_len_bits;
    logic         dbg_state;

    sha2_pad #(.ID_BITS(8), .CNT_BITS(61)) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tid(s_tid), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tid(m_tid), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .msg_done(msg_done), .msg_len_bits(msg_len_bits), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    int           n_checks = 0;
    int           n_pass = 0;
    int           rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
    logic [520:0] exp_q[$];      // {tid, last, data}
    logic [63:0]  len_q[$];
    logic [7:0]   msg_bytes[$];
    logic [511:0] obs_blk[8];
    int           obs_n = 0;
    int           bubbles = 0;
    logic [63:0]  last_len = '0;

    task automatic check(input string name, input logic [520:0] act, input logic [520:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input int got, input int limit);
        n_checks++;
        $display("FAIL %s: got %0d cycles, limit %0d", name, got, limit);
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append bit length big-endian.
    task automatic push_expected(input logic [7:0] tid);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] d;
        logic         lastb;
        int           nblk;
        p = msg_bytes;
        bits = 64'(msg_bytes.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 7; j >= 0; j--) p.push_back(bits[8*j +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 64; k++) d[8*k +: 8] = p[64*b + k];
            lastb = (b == nblk - 1);
            exp_q.push_back({tid, lastb, d});
        end
        len_q.push_back(bits);
    endtask

    // driver tasks: entered and left at posedge + 1
    task automatic send_beat(input logic [511:0] d, input logic [63:0] keep,
                             input logic [7:0] tid, input logic last);
        int waited = 0;
        s_tdata = d; s_tkeep = keep; s_tid = tid; s_tlast = last; s_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            waited++;
            if (waited > 1000) begin
                fail_now("s_tready_timeout", waited, 1000);
                break;
            end
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        s_tdata = {16{$urandom}};
    endtask

    task automatic send_msg(input logic [7:0] tid, input bit gaps);
        int           len, nbeats, c;
        logic [511:0] d;
        logic [63:0]  keep;
        @(posedge aclk); #1;
        len = msg_bytes.size();
        nbeats = (len == 0) ? 1 : (len + 63) / 64;
        push_expected(tid);
        for (int b = 0; b < nbeats; b++) begin
            c = (b == nbeats - 1) ? len - 64*b : 64;
            for (int k = 0; k < 64; k++) begin
                if (k < c) d[8*k +: 8] = msg_bytes[64*b + k];
                else d[8*k +: 8] = 8'($urandom);
            end
            if (b != nbeats - 1) keep = {$urandom, $urandom};
            else if (c == 64) keep = '1;
            else keep = (64'd1 << c) - 64'd1;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            send_beat(d, keep, tid, (b == nbeats - 1));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout", n, 3000);
        repeat (2) @(negedge aclk);
    endtask

    task automatic fill_random(input int len);
        msg_bytes.delete();
        for (int i = 0; i < len; i++) msg_bytes.push_back(8'($urandom));
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // scoreboard / monitor, sampled on the falling edge
    logic         prev_stall = 1'b0;
    logic         prev_hs_last = 1'b0;
    logic [520:0] prev_out = '0;
    logic [520:0] got_blk;
    logic [63:0]  exp_len;

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
            prev_hs_last = 1'b0;
        end else begin
            got_blk = {m_tid, m_tlast, m_tdata};
            if (prev_stall) begin
                check("stall_valid", 521'(m_tvalid), 521'(1));
                check("stall_payload", got_blk, prev_out);
            end
            check("msg_done", 521'(msg_done), 521'(prev_hs_last));
            if (msg_done) begin
                if (len_q.size() == 0) begin
                    check("unexpected_msg_done", 521'(msg_done), 521'(0));
                end else begin
                    exp_len = len_q.pop_front();
                    check("msg_len_bits", 521'(msg_len_bits), 521'(exp_len));
                end
                last_len = msg_len_bits;
            end
            if (!s_tready) bubbles++;
            if (m_tvalid && m_tready) begin
                check("m_tkeep", 521'(m_tkeep), 521'(64'hFFFF_FFFF_FFFF_FFFF));
                if (exp_q.size() == 0) check("unexpected_block", 521'(m_tvalid), 521'(0));
                else check("block", got_blk, exp_q.pop_front());
                if (obs_n < 8) obs_blk[obs_n] = m_tdata;
                obs_n++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out = got_blk;
            prev_hs_last = m_tvalid && m_tready && m_tlast;
        end
    end

    typedef struct {
        int         len;
        int         nblk;
        logic [63:0] bits;
        int         b0;
        int         l0;
        logic [7:0] v0;
        int         b1;
        int         l1;
        logic [7:0] v1;
        int         bub;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int len;
        vecs[0] = '{3,   1, 64'd24,   0, 3,  8'h80, 0, 63, 8'h18, 0};
        vecs[1] = '{0,   1, 64'd0,    0, 0,  8'h80, 0, 63, 8'h00, 0};
        vecs[2] = '{55,  1, 64'd440,  0, 55, 8'h80, 0, 63, 8'hB8, 0};
        vecs[3] = '{56,  2, 64'd448,  0, 56, 8'h80, 1, 63, 8'hC0, 1};
        vecs[4] = '{63,  2, 64'd504,  0, 63, 8'h80, 1, 63, 8'hF8, 1};
        vecs[5] = '{64,  2, 64'd512,  1, 0,  8'h80, 1, 62, 8'h02, 1};
        vecs[6] = '{128, 3, 64'd1024, 2, 0,  8'h80, 2, 62, 8'h04, 1};

        #1 areset = 1'b1;
        #20;
        check("rst_m_tvalid", 521'(m_tvalid), 521'(0));
        check("rst_m_tlast", 521'(m_tlast), 521'(0));
        check("rst_m_tdata", 521'(m_tdata), 521'(0));
        check("rst_m_tid", 521'(m_tid), 521'(0));
        check("rst_msg_done", 521'(msg_done), 521'(0));
        check("rst_msg_len_bits", 521'(msg_len_bits), 521'(0));
        check("rst_s_tready", 521'(s_tready), 521'(1));
        check("rst_state", 521'(dbg_state), 521'(0));
        @(posedge aclk); #1 areset = 1'b0;

        // table-driven boundary lengths, output always ready
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].len == 3) begin
                msg_bytes.delete();
                msg_bytes.push_back(8'h61); msg_bytes.push_back(8'h62); msg_bytes.push_back(8'h63);
            end else begin
                fill_random(vecs[i].len);
            end
            obs_n = 0; bubbles = 0;
            send_msg(8'(i + 1), 1'b0);
            wait_idle();
            check("vec_nblk", 521'(obs_n), 521'(vecs[i].nblk));
            check("vec_len_bits", 521'(last_len), 521'(vecs[i].bits));
            check("vec_lane_a", 521'(obs_blk[vecs[i].b0][8*vecs[i].l0 +: 8]), 521'(vecs[i].v0));
            check("vec_lane_b", 521'(obs_blk[vecs[i].b1][8*vecs[i].l1 +: 8]), 521'(vecs[i].v1));
            check("vec_bubbles", 521'(bubbles), 521'(vecs[i].bub));
        end

        // reset while a padded block is pending
        rdy_mode = 2;
        @(posedge aclk); #1;
        fill_random(56);
        send_msg(8'h44, 1'b0);
        @(posedge aclk); #3;
        check("extra_state", 521'(dbg_state), 521'(1));
        check("extra_s_tready", 521'(s_tready), 521'(0));
        areset = 1'b1;
        #1;
        check("abort_m_tvalid", 521'(m_tvalid), 521'(0));
        check("abort_msg_done", 521'(msg_done), 521'(0));
        exp_q.delete(); len_q.delete();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        rdy_mode = 0;
        check("abort_state", 521'(dbg_state), 521'(0));
        msg_bytes.delete();
        msg_bytes.push_back(8'h61); msg_bytes.push_back(8'h62); msg_bytes.push_back(8'h63);
        obs_n = 0; last_len = '0;
        send_msg(8'h45, 1'b0);
        wait_idle();
        check("post_abort_nblk", 521'(obs_n), 521'(1));
        check("post_abort_len", 521'(last_len), 521'(24));
        check("post_abort_pad", 521'(obs_blk[0][8*3 +: 8]), 521'(8'h80));

        // randomized lengths with backpressure and input gaps
        rdy_mode = 1;
        for (int m = 0; m < 100; m++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: len = 0;
                    1: len = 55;
                    2: len = 56;
                    3: len = 63;
                    4: len = 64;
                    default: len = 128;
                endcase
            end else begin
                len = $urandom_range(0, 200);
            end
            fill_random(len);
            send_msg(8'(m + 16), 1'b1);
        end
        wait_idle();
        check("final_exp_q_empty", 521'(exp_q.size()), 521'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got %0t, limit 3000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
